// File: rtl/bundle_sched.sv
// Training-session scheduler that feeds labelled hypervectors to per-class bundlers one at a time.
// Optional WAIT-state watchdog is enabled by defining BUNDLE_SCHED_TIMEOUT_EN.
module bundle_sched #(
   parameter int DIMENSIONS        = 10000,
   parameter int NUM_CLASSES       = 2,
   parameter int CLASS_BITS        = 1,
   parameter int SAMPLES_PER_CLASS = 16,
   parameter int TIMEOUT_CYCLES    = 1024
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIMENSIONS-1:0] in_hv,
   input  logic [CLASS_BITS-1:0] in_label,
   output logic                  bnd_en,
   output logic [CLASS_BITS-1:0] bnd_sel,
   output logic [DIMENSIONS-1:0] bnd_hv,
   input  logic                  bnd_done,
   output logic                  busy,
   output logic                  train_done,
   output logic                  err_timeout
);

   localparam int CW    = $clog2(SAMPLES_PER_CLASS + 1);
   localparam int NSLOT = 1 << CLASS_BITS;
   localparam logic [CW-1:0]       SPC  = SAMPLES_PER_CLASS[CW-1:0];
   localparam logic [CLASS_BITS:0] NC_W = NUM_CLASSES[CLASS_BITS:0];

   if ((NSLOT < NUM_CLASSES) || (TIMEOUT_CYCLES < 1)) begin : g_bad_cfg
      $error("bundle_sched: CLASS_BITS too small for NUM_CLASSES or TIMEOUT_CYCLES < 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_ISSUE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t                state_q;
   logic [CW-1:0]         cnt_q [NSLOT];
   logic [DIMENSIONS-1:0] bnd_hv_q;
   logic [CLASS_BITS-1:0] bnd_sel_q;
   logic                  bnd_en_q;
   logic                  in_ready_q;
   logic                  busy_q;
   logic                  train_done_q;
   logic                  err_timeout_q;
   logic                  all_full_d;
   logic                  label_ok_d;

`ifdef BUNDLE_SCHED_TIMEOUT_EN
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam int TO_M1 = TIMEOUT_CYCLES - 1;
   localparam logic [TW-1:0] TO_LAST = TO_M1[TW-1:0];
   logic [TW-1:0] wait_cnt_q;
`endif

   // Unused select slots above NUM_CLASSES never increment, so only real classes decide completion.
   always_comb begin
      all_full_d = 1'b1;
      for (int i = 0; i < NUM_CLASSES; i++) begin
         if (cnt_q[i] != SPC) all_full_d = 1'b0;
      end
      label_ok_d = ({1'b0, in_label} < NC_W) && (cnt_q[in_label] < SPC);
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q       <= S_IDLE;
         for (int i = 0; i < NSLOT; i++) cnt_q[i] <= '0;
         bnd_hv_q      <= '0;
         bnd_sel_q     <= '0;
         bnd_en_q      <= 1'b0;
         in_ready_q    <= 1'b0;
         busy_q        <= 1'b0;
         train_done_q  <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef BUNDLE_SCHED_TIMEOUT_EN
         wait_cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  for (int i = 0; i < NSLOT; i++) cnt_q[i] <= '0;
                  state_q    <= S_ACCEPT;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
               end
            end
            S_ACCEPT: begin
               if (in_valid) begin
                  bnd_hv_q  <= in_hv;
                  bnd_sel_q <= in_label;
                  if (label_ok_d) begin
                     state_q    <= S_ISSUE;
                     in_ready_q <= 1'b0;
                     bnd_en_q   <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               bnd_en_q          <= 1'b0;
               cnt_q[bnd_sel_q]  <= cnt_q[bnd_sel_q] + CW'(1);
               state_q           <= S_WAIT;
`ifdef BUNDLE_SCHED_TIMEOUT_EN
               wait_cnt_q        <= '0;
`endif
            end
            S_WAIT: begin
               if (bnd_done) begin
                  if (all_full_d) begin
                     state_q      <= S_FINISH;
                     train_done_q <= 1'b1;
                  end else begin
                     state_q    <= S_ACCEPT;
                     in_ready_q <= 1'b1;
                  end
               end
`ifdef BUNDLE_SCHED_TIMEOUT_EN
               else if (wait_cnt_q == TO_LAST) begin
                  err_timeout_q <= 1'b1;
                  busy_q        <= 1'b0;
                  state_q       <= S_IDLE;
               end else begin
                  wait_cnt_q <= wait_cnt_q + TW'(1);
               end
`endif
            end
            S_FINISH: begin
               train_done_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            default: begin
               state_q    <= S_IDLE;
               bnd_en_q   <= 1'b0;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign bnd_en      = bnd_en_q;
   assign bnd_sel     = bnd_sel_q;
   assign bnd_hv      = bnd_hv_q;
   assign busy        = busy_q;
   assign train_done  = train_done_q;
   assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_bundle_sched.sv
// Directed self-checking bench for bundle_sched: 2 classes, 2 samples per class, 6-bit vectors.
module tb_bundle_sched;

   localparam int DIM = 6;
   localparam int CB  = 2;

   logic           clk = 1'b0;
   logic           nrst;
   logic           start;
   logic           in_valid;
   logic           in_ready;
   logic [DIM-1:0] in_hv;
   logic [CB-1:0]  in_label;
   logic           bnd_en;
   logic [CB-1:0]  bnd_sel;
   logic [DIM-1:0] bnd_hv;
   logic           bnd_done;
   logic           busy;
   logic           train_done;
   logic           err_timeout;

   int checks   = 0;
   int failures = 0;

   bundle_sched #(
      .DIMENSIONS(DIM),
      .NUM_CLASSES(2),
      .CLASS_BITS(CB),
      .SAMPLES_PER_CLASS(2),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk(clk),
      .nrst(nrst),
      .start(start),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_hv(in_hv),
      .in_label(in_label),
      .bnd_en(bnd_en),
      .bnd_sel(bnd_sel),
      .bnd_hv(bnd_hv),
      .bnd_done(bnd_done),
      .busy(busy),
      .train_done(train_done),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [CB-1:0] lbl, input logic [DIM-1:0] hv);
      in_valid = v;
      in_label = lbl;
      in_hv    = hv;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_bnd_en"}, 32'(bnd_en), 32'd0);
      checkOutput({tag, "_bnd_sel"}, 32'(bnd_sel), 32'd0);
      checkOutput({tag, "_bnd_hv"}, 32'(bnd_hv), 32'd0);
      checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_train_done"}, 32'(train_done), 32'd0);
      checkOutput({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
   endtask

   // Handshake in ACCEPT, expect bnd_en next cycle, hold WAIT, return bnd_done 'delay' cycles after bnd_en.
   task automatic sendSample(input logic [CB-1:0] lbl, input logic [DIM-1:0] hv,
                             input int delay, input bit lastOne);
      applyStimulus(1'b1, lbl, hv);
      step();
      applyStimulus(1'b0, 2'd0, 6'd0);
      checkOutput("issue_bnd_en", 32'(bnd_en), 32'd1);
      checkOutput("issue_bnd_sel", 32'(bnd_sel), 32'(lbl));
      checkOutput("issue_bnd_hv", 32'(bnd_hv), 32'(hv));
      checkOutput("issue_in_ready", 32'(in_ready), 32'd0);
      step();
      checkOutput("wait_bnd_en", 32'(bnd_en), 32'd0);
      for (int i = 1; i < delay; i++) begin
         step();
         checkOutput("wait_in_ready", 32'(in_ready), 32'd0);
         checkOutput("wait_bnd_hv", 32'(bnd_hv), 32'(hv));
      end
      bnd_done = 1'b1;
      checkOutput("done_in_ready", 32'(in_ready), 32'd0);
      step();
      bnd_done = 1'b0;
      if (lastOne) begin
         checkOutput("finish_train_done", 32'(train_done), 32'd1);
         checkOutput("finish_busy", 32'(busy), 32'd1);
         checkOutput("finish_in_ready", 32'(in_ready), 32'd0);
      end else begin
         checkOutput("after_done_in_ready", 32'(in_ready), 32'd1);
         checkOutput("after_done_train_done", 32'(train_done), 32'd0);
      end
   endtask

   task automatic dropSample(input logic [CB-1:0] lbl, input logic [DIM-1:0] hv);
      applyStimulus(1'b1, lbl, hv);
      step();
      applyStimulus(1'b0, 2'd0, 6'd0);
      checkOutput("drop_bnd_en", 32'(bnd_en), 32'd0);
      checkOutput("drop_in_ready", 32'(in_ready), 32'd1);
      checkOutput("drop_bnd_hv", 32'(bnd_hv), 32'(hv));
      checkOutput("drop_bnd_sel", 32'(bnd_sel), 32'(lbl));
      step();
      checkOutput("drop_no_late_bnd_en", 32'(bnd_en), 32'd0);
   endtask

   initial begin
      nrst     = 1'b0;
      start    = 1'b0;
      bnd_done = 1'b0;
      applyStimulus(1'b0, 2'd0, 6'd0);
      step();
      step();
      checkResetOutputs("reset");
      nrst = 1'b1;
      step();
      checkOutput("idle_no_start_in_ready", 32'(in_ready), 32'd0);
      checkOutput("idle_no_start_busy", 32'(busy), 32'd0);

      // Session 1: samples 0,1,0 acknowledged, then two drops, a stray start, and the final label 1.
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("start_in_ready", 32'(in_ready), 32'd1);
      checkOutput("start_busy", 32'(busy), 32'd1);
      sendSample(2'd0, 6'b100001, 5, 1'b0);
      sendSample(2'd1, 6'b010110, 2, 1'b0);
      sendSample(2'd0, 6'b111000, 1, 1'b0);
      dropSample(2'd0, 6'b001100);
      dropSample(2'd3, 6'b000011);
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("start_ignored_in_ready", 32'(in_ready), 32'd1);
      checkOutput("start_ignored_busy", 32'(busy), 32'd1);
      sendSample(2'd1, 6'b110011, 1, 1'b1);
      step();
      checkOutput("post_finish_train_done", 32'(train_done), 32'd0);
      checkOutput("post_finish_busy", 32'(busy), 32'd0);
      step();
      checkOutput("idle_train_done", 32'(train_done), 32'd0);
      checkOutput("idle_in_ready", 32'(in_ready), 32'd0);

      // Session 2: reset asserted mid-WAIT.
      start = 1'b1;
      step();
      start = 1'b0;
      applyStimulus(1'b1, 2'd0, 6'b101010);
      step();
      applyStimulus(1'b0, 2'd0, 6'd0);
      checkOutput("s2_bnd_en", 32'(bnd_en), 32'd1);
      step();
      checkOutput("s2_wait_busy", 32'(busy), 32'd1);
      #2;
      nrst = 1'b0;
      #1;
      checkResetOutputs("async_reset");
      step();
      nrst     = 1'b1;
      bnd_done = 1'b1;
      step();
      bnd_done = 1'b0;
      checkOutput("post_reset_bnd_en", 32'(bnd_en), 32'd0);
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      step();
      step();
      checkOutput("post_reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("post_reset_train_done", 32'(train_done), 32'd0);

      // Session 3: bnd_done withheld.
      start = 1'b1;
      step();
      start = 1'b0;
      applyStimulus(1'b1, 2'd1, 6'b000111);
      step();
      applyStimulus(1'b0, 2'd0, 6'd0);
      checkOutput("s3_bnd_en", 32'(bnd_en), 32'd1);
      step();
      for (int i = 2; i <= 8; i++) begin
         step();
         checkOutput("s3_wait_err", 32'(err_timeout), 32'd0);
         checkOutput("s3_wait_busy", 32'(busy), 32'd1);
         checkOutput("s3_wait_train_done", 32'(train_done), 32'd0);
      end
      step();
`ifdef BUNDLE_SCHED_TIMEOUT_EN
      checkOutput("timeout_err", 32'(err_timeout), 32'd1);
      checkOutput("timeout_busy", 32'(busy), 32'd0);
      checkOutput("timeout_train_done", 32'(train_done), 32'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      checkOutput("timeout_sticky_err", 32'(err_timeout), 32'd1);
      checkOutput("timeout_restart_in_ready", 32'(in_ready), 32'd1);
`else
      checkOutput("no_watchdog_err", 32'(err_timeout), 32'd0);
      checkOutput("no_watchdog_busy", 32'(busy), 32'd1);
      checkOutput("no_watchdog_in_ready", 32'(in_ready), 32'd0);
      checkOutput("no_watchdog_train_done", 32'(train_done), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bundle_sched.md
BUNDLE_SCHED -- requirements
Module: bundle_sched

Interface
REQ-001 Parameter DIMENSIONS, default 10000, hypervector width in bits.
REQ-002 Parameter NUM_CLASSES, default 2, number of per-class bundlers sequenced.
REQ-003 Parameter CLASS_BITS, default 1, label/select width; SHALL satisfy 2**CLASS_BITS >= NUM_CLASSES.
REQ-004 Parameter SAMPLES_PER_CLASS, default 16, training samples bundled per class per session.
REQ-005 Parameter TIMEOUT_CYCLES, default 1024, bnd_done watchdog limit.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 nrst  in  1  asynchronous active-low reset.
REQ-008 start  in  1  one-cycle pulse, begins a training session.
REQ-009 in_valid  in  1  training hypervector offered.
REQ-010 in_ready  out  1  scheduler accepts in_hv/in_label this cycle.
REQ-011 in_hv  in  DIMENSIONS  training hypervector.
REQ-012 in_label  in  CLASS_BITS  class of in_hv.
REQ-013 bnd_en  out  1  one-cycle enable to the selected bundler.
REQ-014 bnd_sel  out  CLASS_BITS  index of the bundler addressed.
REQ-015 bnd_hv  out  DIMENSIONS  registered hypervector driven to bundlers.
REQ-016 bnd_done  in  1  completion from the selected bundler.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 train_done  out  1  one-cycle pulse at session end.
REQ-019 err_timeout  out  1  sticky watchdog flag.

Function
REQ-020 States: IDLE, ACCEPT, ISSUE, WAIT, FINISH; one per-class sample counter, width clog2(SAMPLES_PER_CLASS+1).
REQ-021 IDLE: start=1 -> clear all counters, ACCEPT next cycle; start ignored in all other states.
REQ-022 ACCEPT: in_ready=1; in_valid&in_ready captures in_hv into bnd_hv and in_label into bnd_sel.
REQ-023 Captured label < NUM_CLASSES with counter < SAMPLES_PER_CLASS -> ISSUE; else sample dropped silently, stay ACCEPT, no counter change.
REQ-024 ISSUE: bnd_en=1 exactly one cycle, counter[bnd_sel] increments, -> WAIT; latency handshake-to-bnd_en = 1 cycle.
REQ-025 WAIT: in_ready=0; bnd_en=0; bnd_hv and bnd_sel held stable; bnd_done=1 -> FINISH if every counter equals SAMPLES_PER_CLASS, else ACCEPT.
REQ-026 bnd_done SHALL be ignored outside WAIT; bnd_done may arrive earliest the cycle after bnd_en.
REQ-027 FINISH: train_done=1 for one cycle, -> IDLE; counters retain final values.
REQ-028 in_ready SHALL be high only in ACCEPT; no combinational path in_valid -> in_ready.

Reset
REQ-029 nrst=0 asynchronously forces IDLE, counters 0, bnd_hv 0, bnd_sel 0, bnd_en 0, in_ready 0, busy 0, train_done 0, err_timeout 0.
REQ-030 Reset mid-WAIT abandons the outstanding bundle with no further bnd_en; first post-reset transition requires a new start.

Configuration
REQ-031 Macro BUNDLE_SCHED_TIMEOUT_EN defined: WAIT cycle counter; TIMEOUT_CYCLES cycles in WAIT without bnd_done -> err_timeout set (sticky until reset), -> IDLE without train_done.
REQ-032 Macro undefined: no watchdog logic, WAIT holds indefinitely, err_timeout tied 0.

Verification
REQ-033 NUM_CLASSES=2, SAMPLES_PER_CLASS=2, DIMENSIONS=6: start; send label0 6'b100001 -> bnd_en one cycle after handshake, bnd_sel=0, bnd_hv=6'b100001.
REQ-034 Same config, bnd_done returned 5 cycles after bnd_en; in_ready stays 0 throughout WAIT, rises the cycle after bnd_done.
REQ-035 Four samples labels 0,1,0,1 each acknowledged -> train_done single pulse one cycle after fourth bnd_done, busy falls next cycle.
REQ-036 Third label-0 sample after class 0 full, and label 3 sample -> accepted, no bnd_en, counters unchanged.
REQ-037 nrst pulled low during WAIT -> all outputs at reset values immediately; start ignored while busy (no counter clear).
REQ-038 With BUNDLE_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8, bnd_done withheld -> err_timeout=1 after 8 WAIT cycles, IDLE, train_done never asserted.
